// File: rtl/regfile_pkg.sv
// Shared widths and types for the register-file burst master and its response FIFO.
package regfile_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } rfm_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } rfm_rsp_t;

endpackage

// File: rtl/regfile_burst_master_chk.sv
// Protocol checker for the register-file side of regfile_burst_master.
module regfile_burst_master_chk (
  input logic clk,
  input logic reset,
  input logic rf_wr,
  input logic rf_rd
);

  a_rd_wr_excl: assert property (@(posedge clk) disable iff (reset) !(rf_wr && rf_rd))
    else $error("rf_rd and rf_wr high in the same cycle");

endmodule

// File: rtl/rfm_rsp_fifo.sv
// Synchronous FIFO of read responses; a push on a full FIFO is accepted only
// together with a pop.
module rfm_rsp_fifo
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  rfm_rsp_t         push_data,
  input  logic             pop,
  output rfm_rsp_t         head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  rfm_rsp_t         mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // Qualify push/pop against occupancy.
  always_comb begin
    do_pop_s  = pop && (cnt_r != {CNT_W{1'b0}});
    do_push_s = push && ((cnt_r != CNT_W'(DEPTH)) || do_pop_s);
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign empty = (cnt_r == {CNT_W{1'b0}});
  assign count = cnt_r;

endmodule

// File: rtl/regfile_burst_master.sv
// Burst command sequencer driving a single-beat register-file port; read data
// returns through a credit-limited response FIFO.
module regfile_burst_master
  import regfile_pkg::*;
#(
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  output logic              rf_wr,
  output logic              rf_rd,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_din,
  input  logic [DATA_W-1:0] rf_dout,
  input  logic              rf_error,
  output logic              busy,
  output logic              done,
  output logic              done_err
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  rfm_state_t        state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W:0]    beat_r;
  logic              beats_open_r;
  logic              rd_last_r;
  logic              pend_r;
  logic              pend_last_r;
  logic              err_r;
  logic              rf_wr_r;
  logic              rf_rd_r;
  logic [ADDR_W-1:0] rf_addr_r;
  logic [DATA_W-1:0] rf_din_r;
  logic              done_r;
  logic              done_err_r;

  rfm_rsp_t          push_data_s;
  rfm_rsp_t          head_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  fifo_cnt_s;
  logic [CNT_W:0]    used_s;
  logic              push_s;
  logic              pop_s;
  logic              last_beat_s;
  logic              wr_beat_s;
  logic              rd_issue_s;

  // Credits count FIFO entries plus the issue and response stages of the read pipe.
  always_comb begin
    used_s       = {1'b0, fifo_cnt_s} + {{CNT_W{1'b0}}, rf_rd_r} + {{CNT_W{1'b0}}, pend_r};
    last_beat_s  = (beat_r == {1'b0, len_r});
    wr_beat_s    = (state_r == WRITE) && beats_open_r && wdata_valid;
    rd_issue_s   = (state_r == READ) && beats_open_r && (used_s < (CNT_W + 1)'(RSP_DEPTH));
    push_s       = pend_r;
    pop_s        = rdata_ready && !fifo_empty_s;
    push_data_s.data = rf_error ? {DATA_W{1'b0}} : rf_dout;
    push_data_s.last = pend_last_r;
  end

  // Burst FSM, address/beat tracking and all registered port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      addr_r       <= {ADDR_W{1'b0}};
      len_r        <= {LEN_W{1'b0}};
      beat_r       <= {(LEN_W + 1){1'b0}};
      beats_open_r <= 1'b0;
      rd_last_r    <= 1'b0;
      pend_r       <= 1'b0;
      pend_last_r  <= 1'b0;
      err_r        <= 1'b0;
      rf_wr_r      <= 1'b0;
      rf_rd_r      <= 1'b0;
      rf_addr_r    <= {ADDR_W{1'b0}};
      rf_din_r     <= {DATA_W{1'b0}};
      done_r       <= 1'b0;
      done_err_r   <= 1'b0;
    end else begin
      rf_wr_r     <= 1'b0;
      rf_rd_r     <= 1'b0;
      done_r      <= 1'b0;
      done_err_r  <= 1'b0;
      pend_r      <= rf_rd_r;
      pend_last_r <= rf_rd_r && rd_last_r;
      if (push_s && rf_error) err_r <= 1'b1;
      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state_r      <= cmd_write ? WRITE : READ;
            addr_r       <= cmd_addr;
            len_r        <= cmd_len;
            beat_r       <= {(LEN_W + 1){1'b0}};
            beats_open_r <= 1'b1;
            err_r        <= 1'b0;
          end
        end
        WRITE: begin
          if (wr_beat_s) begin
            rf_wr_r   <= 1'b1;
            rf_addr_r <= addr_r;
            rf_din_r  <= wdata;
            addr_r    <= addr_r + ADDR_W'(1);
            beat_r    <= beat_r + (LEN_W + 1)'(1);
            if (last_beat_s) beats_open_r <= 1'b0;
          end else if (!beats_open_r) begin
            // Final rf_wr cycle has just ended.
            state_r    <= DONE;
            done_r     <= 1'b1;
            done_err_r <= err_r;
          end
        end
        READ: begin
          if (rd_issue_s) begin
            rf_rd_r   <= 1'b1;
            rf_addr_r <= addr_r;
            rd_last_r <= last_beat_s;
            addr_r    <= addr_r + ADDR_W'(1);
            beat_r    <= beat_r + (LEN_W + 1)'(1);
            if (last_beat_s) beats_open_r <= 1'b0;
          end
          if (push_s && pend_last_r) begin
            state_r    <= DONE;
            done_r     <= 1'b1;
            done_err_r <= err_r || rf_error;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  rfm_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .empty     (fifo_empty_s),
    .count     (fifo_cnt_s)
  );

  assign cmd_ready   = (state_r == IDLE) && fifo_empty_s && !rf_rd_r && !pend_r;
  assign wdata_ready = (state_r == WRITE) && beats_open_r;
  assign rdata_valid = !fifo_empty_s;
  assign rdata       = fifo_empty_s ? {DATA_W{1'b0}} : head_s.data;
  assign rdata_last  = !fifo_empty_s && head_s.last;
  assign rf_wr       = rf_wr_r;
  assign rf_rd       = rf_rd_r;
  assign rf_addr     = rf_addr_r;
  assign rf_din      = rf_din_r;
  assign busy        = (state_r != IDLE) || !fifo_empty_s || rf_rd_r || pend_r;
  assign done        = done_r;
  assign done_err    = done_err_r;

endmodule
